// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit sitting beside the ALU in execute.
// One operation in flight; divide-by-zero and signed overflow resolve at accept without iterating.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [2:0]            op_i,
  input  logic [DATA_WIDTH-1:0] srcA_i,
  input  logic [DATA_WIDTH-1:0] srcB_i,
  input  logic                  flush_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o
);
  localparam int W = DATA_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t               state, state_next;
  logic [2:0]           op_q;
  logic [W-1:0]         operand;   // multiplicand magnitude or divisor magnitude
  logic [2*W-1:0]       acc;       // mul: {hi, multiplier}; div: {rem, quot}
  logic                 neg_main;  // negate product or quotient
  logic                 neg_rem;
  logic [CNT_WIDTH-1:0] cnt;

  logic         accept, is_div, signed_a, signed_b, sa, sb;
  logic [W-1:0] abs_a, abs_b, special_result;
  logic         div_zero, div_ovf, special, last_iter;

  always_comb begin
    accept   = start_i && (state != S_CALC) && !flush_i;
    is_div   = op_i[2];
    signed_a = (op_i == 3'b001) || (op_i == 3'b010) || (op_i == 3'b100) || (op_i == 3'b110);
    signed_b = (op_i == 3'b001) || (op_i == 3'b100) || (op_i == 3'b110);
    sa       = signed_a && srcA_i[W-1];
    sb       = signed_b && srcB_i[W-1];
    abs_a    = sa ? -srcA_i : srcA_i;
    abs_b    = sb ? -srcB_i : srcB_i;
    div_zero = is_div && (srcB_i == '0);
    div_ovf  = is_div && !op_i[0] && (srcA_i == {1'b1, {(W-1){1'b0}}}) && (srcB_i == '1);
    special  = div_zero || div_ovf;
    // Overflow quotient equals the dividend (0x80000000), remainder is 0.
    if (div_zero) special_result = op_i[1] ? srcA_i : '1;
    else          special_result = op_i[1] ? '0 : srcA_i;
  end

  // One radix-2 iteration of either algorithm, plus the final sign fix-up.
  logic [W:0]     mul_sum, partial;
  logic           ge;
  logic [W-1:0]   diff, quot, rem;
  logic [2*W-1:0] acc_step, prod;
  logic [W-1:0]   final_result;

  always_comb begin
    mul_sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, operand} : '0);
    partial = acc[2*W-1:W-1];
    ge      = partial >= {1'b0, operand};
    diff    = partial[W-1:0] - operand;
    if (op_q[2]) acc_step = ge ? {diff, acc[W-2:0], 1'b1} : {acc[2*W-2:0], 1'b0};
    else         acc_step = {mul_sum, acc[W-1:1]};
    prod = neg_main ? -acc_step : acc_step;
    quot = neg_main ? -acc_step[W-1:0] : acc_step[W-1:0];
    rem  = neg_rem  ? -acc_step[2*W-1:W] : acc_step[2*W-1:W];
    unique case (op_q)
      3'b000:                 final_result = prod[W-1:0];
      3'b001, 3'b010, 3'b011: final_result = prod[2*W-1:W];
      3'b100, 3'b101:         final_result = quot;
      default:                final_result = rem;
    endcase
    last_iter = (cnt == CNT_WIDTH'(W-1));
  end

  // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_next = state;
    if (flush_i) begin
      state_next = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:  if (start_i) state_next = special ? S_DONE : S_CALC;
        S_CALC:  if (last_iter) state_next = S_DONE;
        S_DONE:  state_next = start_i ? (special ? S_DONE : S_CALC) : S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q     <= '0;
      operand  <= '0;
      acc      <= '0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      cnt      <= '0;
      result_o <= '0;
    end else if (accept) begin
      op_q     <= op_i;
      operand  <= is_div ? abs_b : abs_a;
      acc      <= {{W{1'b0}}, (is_div ? abs_a : abs_b)};
      neg_main <= sa ^ sb;
      neg_rem  <= sa;
      cnt      <= '0;
      if (special) result_o <= special_result;
    end else if (state == S_CALC && !flush_i) begin
      acc <= acc_step;
      cnt <= cnt + 1'b1;
      if (last_iter) result_o <= final_result;
    end
  end

  assign busy_o = (state == S_CALC);
  assign done_o = (state == S_DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: RV32M vectors, special divide cases, latency, flush, reset, back-to-back.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;
  logic        flush;
  logic        busy, done;
  logic [31:0] result;

  int tests_run = 0;
  int fails = 0;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011,
                         DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  muldiv_unit #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op),
    .srcA_i(src_a), .srcB_i(src_b), .flush_i(flush),
    .busy_o(busy), .done_o(done), .result_o(result)
  );

  always #5 clk = ~clk;

  // Present a request at a negedge, hold it through the accept edge, then drop it.
  task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Called just after the accept edge; returns the cycle number in which done was seen (0 = timeout).
  task automatic wait_done(output int n, output int busy_cnt);
    n = 0;
    busy_cnt = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] expected, input int exp_lat);
    int n, bc;
    launch(o, a, b);
    wait_done(n, bc);
    tests_run++;
    if (n !== exp_lat) begin
      $display("FAIL %s latency: got %0d cycles, want %0d", name, n, exp_lat);
      fails++;
    end
    tests_run++;
    if (result !== expected) begin
      $display("FAIL %s result: got %h, want %h", name, result, expected);
      fails++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; op = '0; src_a = '0; src_b = '0; flush = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({busy, done, result} !== 34'd0) begin
      $display("FAIL reset: busy=%b done=%b result=%h, want 0/0/0", busy, done, result);
      fails++;
    end
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      $display("FAIL post_reset_idle: busy=%b done=%b, want 0/0", busy, done);
      fails++;
    end
  endtask

  task automatic test_mul;
    int n, bc;
    launch(MUL, 32'd7, 32'hFFFF_FFFD);
    wait_done(n, bc);
    tests_run++;
    if (n !== 33) begin $display("FAIL mul_latency: got %0d, want 33", n); fails++; end
    tests_run++;
    if (bc !== 32) begin $display("FAIL mul_busy_cycles: got %0d, want 32", bc); fails++; end
    tests_run++;
    if (result !== 32'hFFFF_FFEB) begin $display("FAIL mul_result: got %h, want ffffffeb", result); fails++; end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL done_single_pulse: done=%b busy=%b, want 0/0", done, busy);
      fails++;
    end
  endtask

  task automatic test_mul_high;
    run_op("mulh",   MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    run_op("mulhu",  MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
  endtask

  task automatic test_div;
    run_op("div_neg",  DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("rem_neg",  REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("divu",     DIVU, 32'd100,       32'd7, 32'd14,        33);
    run_op("remu",     REMU, 32'd100,       32'd7, 32'd2,         33);
  endtask

  task automatic test_special;
    int n, bc;
    launch(DIVU, 32'd5, 32'd0);
    wait_done(n, bc);
    tests_run++;
    if (n !== 1) begin $display("FAIL divu_zero_latency: got %0d, want 1", n); fails++; end
    tests_run++;
    if (bc !== 0) begin $display("FAIL divu_zero_busy: got %0d busy cycles, want 0", bc); fails++; end
    tests_run++;
    if (result !== 32'hFFFF_FFFF) begin $display("FAIL divu_zero_result: got %h, want ffffffff", result); fails++; end
    run_op("rem_zero", REM, 32'd5,         32'd0,         32'd5,         1);
    run_op("div_ovf",  DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf",  REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
  endtask

  task automatic test_flush;
    int done_seen;
    run_op("pre_flush_divu", DIVU, 32'd100, 32'd7, 32'd14, 33);
    launch(DIV, 32'hFFFF_FFF9, 32'd2);
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      $display("FAIL flush_idle: busy=%b done=%b, want 0/0", busy, done);
      fails++;
    end
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    tests_run++;
    if (done_seen !== 0) begin $display("FAIL flush_no_done: got %0d done cycles, want 0", done_seen); fails++; end
    tests_run++;
    if (result !== 32'd14) begin $display("FAIL flush_result_held: got %h, want 0000000e", result); fails++; end
    run_op("mul_after_flush", MUL, 32'd3, 32'd4, 32'd12, 33);
  endtask

  task automatic test_reset_mid;
    launch(MUL, 32'd7, 32'd5);
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests_run++;
    if ({busy, done, result} !== 34'd0) begin
      $display("FAIL reset_mid_op: busy=%b done=%b result=%h, want 0/0/0", busy, done, result);
      fails++;
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_back_to_back;
    int n, bc;
    launch(DIVU, 32'd100, 32'd7);
    wait_done(n, bc);
    tests_run++;
    if (n !== 33 || result !== 32'd14) begin
      $display("FAIL b2b_first: got %0d cycles result %h, want 33 cycles 0000000e", n, result);
      fails++;
    end
    // Still inside the DONE cycle: issue the next request immediately.
    start = 1'b1; op = MUL; src_a = 32'd7; src_b = 32'hFFFF_FFFD;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(n, bc);
    tests_run++;
    if (n !== 33) begin $display("FAIL b2b_second_latency: got %0d, want 33", n); fails++; end
    tests_run++;
    if (result !== 32'hFFFF_FFEB) begin $display("FAIL b2b_second_result: got %h, want ffffffeb", result); fails++; end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mul_high();
    test_div();
    test_special();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit in the execute stage, in parallel with the ALU. It takes the same forwarded srcA/srcB operands and returns its result to the execute result mux. Multi-cycle operations stall the pipeline through busy_o. One operation is in flight at a time. Radix-2, one iteration per cycle.

## Interface
- DATA_WIDTH, 32, operand/result width (only 32 supported)
- CNT_WIDTH, 6, iteration counter width (must hold DATA_WIDTH)
- clk_i  input  1  clock, rising edge
- rst_i  input  1  asynchronous, active-high reset
- start_i  input  1  request; sampled only when not busy_o
- op_i  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- srcA_i  input  DATA_WIDTH  rs1 operand (multiplicand/dividend)
- srcB_i  input  DATA_WIDTH  rs2 operand (multiplier/divisor)
- flush_i  input  1  abort current operation (branch mispredict/trap)
- busy_o  output  1  operation in progress; hazard unit stalls on it
- done_o  output  1  one-cycle pulse, result_o valid
- result_o  output  DATA_WIDTH  result, held until next accepted start

## Operation
- States: IDLE, CALC, DONE.
- Accept: start_i=1 in IDLE or DONE.
  - Latch op, operand magnitudes and sign flags.
  - Signed operands: MULH, DIV and REM treat both signed. MULHSU treats only srcA signed.
  - Clear counter. Go to CALC.
  - Exception: special divide cases go straight to DONE.
- Special divide cases, resolved at accept with no iterations:
  - Divisor 0: quotient 0xFFFFFFFF (DIV and DIVU), remainder = srcA (REM and REMU).
  - DIV/REM with srcA=0x80000000 and srcB=0xFFFFFFFF: quotient 0x80000000, remainder 0.
- CALC, multiply:
  - 64-bit product accumulator.
  - Each cycle: if the multiplier LSB is 1, add the multiplicand magnitude into the upper half; then shift right 1.
- CALC, divide:
  - Restoring division on magnitudes.
  - Each cycle: shift {rem, quot} left 1 and trial-subtract the divisor. If the result is non-negative, keep it and set the quotient LSB.
- CALC completion:
  - After exactly DATA_WIDTH iterations, go to DONE.
  - Apply sign fix-up to the 64-bit product or to quotient/remainder:
    - Product negated if the effective signs differ.
    - Quotient negated if sA^sB.
    - Remainder negated if sA.
  - Register into result_o.
- Result select:
  - MUL: low 32 bits.
  - MULH/MULHSU/MULHU: high 32 bits.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- DONE lasts one cycle, then returns to IDLE unless a new start is accepted.
- start_i during CALC: ignored (the pipeline is stalled; the request is not queued).
- flush_i: highest priority after reset.
  - Any state goes to IDLE next edge.
  - No done_o. result_o unchanged.
  - start_i in the same cycle as flush_i is ignored.
- Arithmetic is modulo 2^32 for the result, 64-bit internally for multiply, 33-bit for the divide trial subtract.

## Timing
- Reset values: busy_o=0, done_o=0, result_o=0, state IDLE, counter 0. Reset mid-operation aborts immediately (asynchronous).
- busy_o is combinational from state: 1 only in CALC. It rises the cycle after the accept edge.
- Normal latency:
  - Start sampled at edge T.
  - Iterations at edges T+1 .. T+32.
  - done_o=1 and result_o valid during the cycle after edge T+32.
  - 33 cycles total.
- Special-case latency: done_o=1 during the cycle after edge T. busy_o never rises.
- Back-to-back: start_i in the DONE cycle is accepted. done_o still pulses for the prior op. No idle bubble is needed.
- result_o is registered and changes only on the edge entering DONE.
- done_o is high for exactly one cycle per completed op.

## Test plan
- MUL srcA=7, srcB=0xFFFFFFFD (-3) -> done_o after 33 cycles, result_o=0xFFFFFFEB. busy_o high for exactly 32 cycles.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF, done_o one cycle after accept, busy_o stays 0. REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 with REM 0.
- Flush at iteration 10 of a DIV -> IDLE next edge, no done_o, result_o holds its previous value. A new MUL 3*4 started afterwards -> 12.
- Assert rst_i at iteration 20 -> busy_o, done_o and result_o all 0 immediately. Back-to-back: start in the DONE cycle -> second done_o exactly 33 cycles after the first.
